melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Plays a fixed song table by driving a period value and a tone enable into the downstream square-wave tone generator (buzzer stage). Each table entry gives a pitch code and a duration in beats. The sequencer times each note, inserts a short silent gap between notes for articulation, and supports start, stop and looping. It is the control stage directly upstream of the buzzer.

## Interface
- BEAT_CYCLES, default 12_500_000: clocks per beat (250 ms at 50 MHz).
- GAP_CYCLES, default 1_250_000: silent clocks at the end of every note. Must be less than BEAT_CYCLES.
- SONG_LEN, default 16: number of table entries; the pointer is 4 bits.
- LOOP, default 1: 1 = restart at entry 0 after the end marker; 0 = stop.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; starts playback from entry 0.
- stop  in  1  single-cycle pulse; aborts playback.
- note_period  out  24  tone period minus 1, in clocks; 0 during a rest.
- tone_en  out  1  1 = downstream block sounds note_period.
- note_idx  out  4  index of the current table entry.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse on normal song completion.

## Operation
- Table entry fields:
  - pitch[2:0]: 0 = rest; 1..7 = C4, D4, E4, F4, G4, A4, B4.
  - dur[2:0]: 1..7 beats; dur = 0 is the end-of-song marker.
- Period constants (period minus 1): 190839, 170067, 151514, 143265, 127550, 113635, 101213.
- FSM states: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE
  - Holds tone_en = 0 and busy = 0.
  - On start: ptr ← 0, go to LOAD.
- LOAD (one cycle): read table[ptr].
  - End marker, LOOP = 1, ptr ≠ 0: ptr ← 0, stay in LOAD.
  - End marker otherwise: go to DONE.
  - Normal entry: load the note timer with dur×BEAT_CYCLES − GAP_CYCLES − 1, go to PLAY.
- PLAY
  - tone_en = (pitch ≠ 0).
  - When the timer expires: load GAP_CYCLES − 1, go to GAP.
- GAP
  - tone_en = 0.
  - When the timer expires: ptr ← ptr + 1, go to LOAD.
  - If ptr was SONG_LEN − 1, treat it as reaching the end marker: wrap to 0 if LOOP = 1, otherwise go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- stop in any state other than IDLE:
  - Next state is IDLE, tone_en = 0 on the next cycle, no done pulse.
  - If start and stop arrive on the same cycle, stop wins.
- start while busy is ignored.
- note_period
  - Registered; updated only on entry to PLAY (rest → 0).
  - Held through GAP, LOAD and IDLE.
- Timer: 27-bit down-counter. The maximum 7×BEAT_CYCLES fits.

## Timing
- Reset values: note_period = 0, tone_en = 0, note_idx = 0, busy = 0, done = 0, state = IDLE.
- All outputs are registered.
- start sampled at cycle 0:
  - busy = 1 at cycle 1 (LOAD).
  - tone_en and note_period valid at cycle 2 (PLAY).
- Per note:
  - tone_en high for dur×BEAT_CYCLES − GAP_CYCLES cycles.
  - tone_en low for GAP_CYCLES cycles, plus 1 LOAD cycle.
  - Note slot = dur×BEAT_CYCLES + 1 cycles.
- note_idx changes in the cycle that enters LOAD.
- Reset asserted mid-note: all outputs return to their reset values immediately (asynchronous).

## Structure
- Package melody_pkg holds:
  - the pitch-period constants;
  - a typedef for the table entry, {pitch[2:0], dur[2:0]};
  - the song ROM function song_entry(idx). Default content: C4…B4 at 1 beat each, end marker at entry 7, remaining entries are end markers.
  - the FSM state enum.
- Sub-module note_timer: loadable down-counter with load, load_val and expire outputs.
- The FSM and output registers live in melody_sequencer.

## Test plan
All scenarios use BEAT_CYCLES = 100, GAP_CYCLES = 10.
- Basic playback, LOOP = 0: start pulse.
  - tone_en high 90 cycles with note_period = 190839, then low 11 cycles.
  - Then 170067 for 90 cycles, and so on through 101213.
  - After entry 7: done pulse for one cycle, busy = 0.
- Loop, LOOP = 1: after B4, note_idx returns to 0 and C4 (190839) restarts with no done pulse.
- Stop at cycle 150:
  - tone_en = 0 and busy = 0 at cycle 151.
  - note_period held at 170067; done stays 0.
- Start while busy: a second start at cycle 50 has no effect; the note_idx sequence is unchanged.
- Rest and long entry: ROM patched with entry 0 = {0, 3}, entry 1 = end marker.
  - tone_en stays 0 and note_period = 0 for 301 cycles.
  - Then a done pulse.
- Reset mid-note: rst_n low at cycle 40 forces all outputs to 0 in that cycle. A new start after release plays from entry 0.

Source files
------------

// File: rtl/melody_pkg.sv
// melody_pkg: shared definitions for the melody sequencer.
//   - pitch-period constants (period minus 1, in clocks at 50 MHz)
//   - song table entry type {pitch[2:0], dur[2:0]}
//   - song ROM functions (default song and a rest/long-note test song)
//   - FSM state enum
package melody_pkg;

  localparam int TIMER_W  = 27;
  localparam int PERIOD_W = 24;
  localparam int PTR_W    = 4;

  localparam logic [PERIOD_W-1:0] PER_C4 = 24'd190839;
  localparam logic [PERIOD_W-1:0] PER_D4 = 24'd170067;
  localparam logic [PERIOD_W-1:0] PER_E4 = 24'd151514;
  localparam logic [PERIOD_W-1:0] PER_F4 = 24'd143265;
  localparam logic [PERIOD_W-1:0] PER_G4 = 24'd127550;
  localparam logic [PERIOD_W-1:0] PER_A4 = 24'd113635;
  localparam logic [PERIOD_W-1:0] PER_B4 = 24'd101213;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_e;

  // dur == 0 marks the end of the song.
  typedef struct packed {
    logic [2:0] pitch;
    logic [2:0] dur;
  } song_entry_t;

  // Rest (pitch 0) maps to period 0.
  function automatic logic [PERIOD_W-1:0] pitch_period(input logic [2:0] pitch);
    logic [PERIOD_W-1:0] p;
    case (pitch)
      3'd1:    p = PER_C4;
      3'd2:    p = PER_D4;
      3'd3:    p = PER_E4;
      3'd4:    p = PER_F4;
      3'd5:    p = PER_G4;
      3'd6:    p = PER_A4;
      3'd7:    p = PER_B4;
      default: p = '0;
    endcase
    return p;
  endfunction

  // Default song: C4..B4, one beat each, end marker from entry 7 on.
  function automatic song_entry_t song_entry(input logic [PTR_W-1:0] idx);
    song_entry_t e;
    e = '0;
    if (idx < 4'd7) begin
      e.pitch = idx[2:0] + 3'd1;
      e.dur   = 3'd1;
    end
    return e;
  endfunction

  // Alternate song: a 3-beat rest followed by the end marker.
  function automatic song_entry_t song_entry_rest(input logic [PTR_W-1:0] idx);
    song_entry_t e;
    e = '0;
    if (idx == 4'd0) e.dur = 3'd3;
    return e;
  endfunction

endpackage

// File: rtl/melody_sequencer_timer.sv
// note_timer: loadable down-counter used to time notes and gaps.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   expire     : counter is at zero
// The counter parks at zero, so expire stays high until the next load.
module note_timer
  import melody_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load)           cnt_q <= load_val;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a fixed song table into the buzzer stage.
//   clk, rst_n  : clock, async active-low reset
//   start       : pulse, start playback at entry 0 (ignored while busy)
//   stop        : pulse, abort playback (wins over start)
//   note_period : tone period minus 1 for the buzzer, 0 for a rest
//   tone_en     : buzzer enable
//   note_idx    : current table entry
//   busy        : high outside IDLE
//   done        : one-cycle pulse on normal completion
// Every note is dur*BEAT_CYCLES+1 cycles: sounding, silent gap, one LOAD.
// SONG_SEL picks the ROM: 0 = default song, 1 = rest/long-note song.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000,
  parameter int SONG_LEN    = 16,
  parameter int LOOP        = 1,
  parameter int SONG_SEL    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  output logic [PERIOD_W-1:0] note_period,
  output logic                tone_en,
  output logic [PTR_W-1:0]    note_idx,
  output logic                busy,
  output logic                done
);

  localparam logic [TIMER_W-1:0] BEAT_T   = TIMER_W'(BEAT_CYCLES);
  localparam logic [TIMER_W-1:0] GAP_T    = TIMER_W'(GAP_CYCLES);
  localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(SONG_LEN - 1);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                tone_en_q, tone_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  song_entry_t         entry;
  logic [TIMER_W-1:0]  dur_ext;
  logic [TIMER_W-1:0]  note_len;
  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;
  logic                tmr_exp;

  assign entry    = (SONG_SEL == 1) ? song_entry_rest(ptr_q) : song_entry(ptr_q);
  assign dur_ext  = {{(TIMER_W-3){1'b0}}, entry.dur};
  // Sounding part of the note; the gap is carved out of the note's beats.
  assign note_len = dur_ext * BEAT_T - GAP_T - 27'd1;

  note_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    period_d  = period_q;
    tone_en_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          ptr_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (entry.dur == 3'd0) begin
          // Looping from a non-zero pointer retries entry 0; an end marker
          // at entry 0 would loop forever, so that case finishes instead.
          if (LOOP != 0 && ptr_q != '0) ptr_d = '0;
          else                          state_d = ST_DONE;
        end else begin
          tmr_load  = 1'b1;
          tmr_val   = note_len;
          period_d  = pitch_period(entry.pitch);
          tone_en_d = (entry.pitch != 3'd0);
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        tone_en_d = tone_en_q;
        if (tmr_exp) begin
          tmr_load  = 1'b1;
          tmr_val   = GAP_T - 27'd1;
          tone_en_d = 1'b0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_exp) begin
          if (ptr_q == LAST_IDX) begin
            if (LOOP != 0) begin
              ptr_d   = '0;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            ptr_d   = ptr_q + 4'd1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort: freeze pointer and period, silence next cycle.
    if (stop && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      ptr_d     = ptr_q;
      period_d  = period_q;
      tone_en_d = 1'b0;
      tmr_load  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      period_q  <= '0;
      tone_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      period_q  <= period_d;
      tone_en_q <= tone_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign note_period = period_q;
  assign tone_en     = tone_en_q;
  assign note_idx    = ptr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer with BEAT_CYCLES=100, GAP_CYCLES=10.
// Three instances: 0 = default song no loop, 1 = default song looping,
// 2 = rest/long-note song no loop.
module tb_melody_sequencer;

  localparam int BEAT = 100;
  localparam int GAP  = 10;
  localparam int SLEN = 16;

  typedef struct packed {
    logic tone;
    int   period;
    int   idx;      // -1 = not checked
    logic busy;
    logic done;
  } obs_t;

  typedef struct packed {
    logic st;
    logic sp;
    int   n;
    obs_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = '0;
  logic [2:0]  stop_v = '0;
  logic [23:0] np [3];
  logic        te [3];
  logic [3:0]  ni [3];
  logic        bs [3];
  logic        dn [3];

  int n_tests = 0;
  int n_fail  = 0;
  int last_period [3] = '{0, 0, 0};
  obs_t exp_q [$];
  vec_t tbl [$];

  int per_tab [8] = '{0, 190839, 170067, 151514, 143265, 127550, 113635, 101213};

  always #5 clk = ~clk;

  melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(SLEN),
                     .LOOP(0), .SONG_SEL(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]),
    .note_period(np[0]), .tone_en(te[0]), .note_idx(ni[0]), .busy(bs[0]), .done(dn[0]));

  melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(SLEN),
                     .LOOP(1), .SONG_SEL(0)) u_loop (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]),
    .note_period(np[1]), .tone_en(te[1]), .note_idx(ni[1]), .busy(bs[1]), .done(dn[1]));

  melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(SLEN),
                     .LOOP(0), .SONG_SEL(1)) u_rest (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stop(stop_v[2]),
    .note_period(np[2]), .tone_en(te[2]), .note_idx(ni[2]), .busy(bs[2]), .done(dn[2]));

  function automatic obs_t mk(input logic t, input int p, input int i, input logic b, input logic d);
    obs_t o;
    o.tone = t; o.period = p; o.idx = i; o.busy = b; o.done = d;
    return o;
  endfunction

  function automatic vec_t mkv(input logic st, input logic sp, input int n, input obs_t e);
    vec_t v;
    v.st = st; v.sp = sp; v.n = n; v.e = e;
    return v;
  endfunction

  function automatic obs_t get_obs(input int sel);
    return mk(te[sel], int'(np[sel]), int'(ni[sel]), bs[sel], dn[sel]);
  endfunction

  // Song contents as the bench understands them.
  task automatic song(input int sel, input int idx, output int pit, output int dur);
    pit = 0; dur = 0;
    if (sel == 2) begin
      if (idx == 0) dur = 3;
    end else if (idx < 7) begin
      pit = idx + 1; dur = 1;
    end
  endtask

  // Expected outputs for cycles 1..n after the start pulse, note by note.
  task automatic build_model(input int sel, input int p0, input int n);
    int ptr, per, pit, dur;
    bit lp, fin;
    exp_q.delete();
    lp = (sel == 1); per = p0; ptr = 0; fin = 0;
    exp_q.push_back(mk(0, per, ptr, 1, 0));
    while (exp_q.size() < n && !fin) begin
      song(sel, ptr, pit, dur);
      if (dur == 0) begin
        if (lp && ptr != 0) begin
          ptr = 0;
          exp_q.push_back(mk(0, per, ptr, 1, 0));
        end else fin = 1;
      end else begin
        per = per_tab[pit];
        repeat (dur * BEAT - GAP) exp_q.push_back(mk(pit != 0, per, ptr, 1, 0));
        repeat (GAP) exp_q.push_back(mk(0, per, ptr, 1, 0));
        if (ptr == SLEN - 1 && !lp) fin = 1;
        else begin
          ptr = (ptr == SLEN - 1) ? 0 : ptr + 1;
          exp_q.push_back(mk(0, per, ptr, 1, 0));
        end
      end
    end
    if (fin) begin
      exp_q.push_back(mk(0, per, ptr, 1, 1));
      while (exp_q.size() < n) exp_q.push_back(mk(0, per, ptr, 0, 0));
    end
  endtask

  task automatic check(input string name, input int k, input obs_t a, input obs_t e);
    n_tests++;
    if (a.tone !== e.tone || a.period != e.period || a.busy !== e.busy ||
        a.done !== e.done || (e.idx >= 0 && a.idx != e.idx)) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got tone=%0b per=%0d idx=%0d busy=%0b done=%0b, want tone=%0b per=%0d idx=%0d busy=%0b done=%0b",
               name, k, a.tone, a.period, a.idx, a.busy, a.done,
               e.tone, e.period, e.idx, e.busy, e.done);
    end
  endtask

  // Start on instance sel, optionally inject an ignored start at extra_at and
  // a stop at stop_at; compare every cycle against the model.
  task automatic run_trace(input int sel, input int stop_at, input int total,
                           input int extra_at, input string name);
    int n, post;
    obs_t e;
    n = (stop_at > 0) ? stop_at : total;
    post = (stop_at > 0) ? 3 : 0;
    build_model(sel, last_period[sel], n);
    e = exp_q[0];
    start_v[sel] = 1'b1;
    for (int k = 1; k <= n + post; k++) begin
      @(posedge clk); #1;
      start_v = '0; stop_v = '0;
      @(negedge clk);
      if (k <= n) e = exp_q[k-1];
      else        e = mk(0, exp_q[n-1].period, -1, 0, 0);
      check(name, k, get_obs(sel), e);
      if (k == extra_at) start_v[sel] = 1'b1;
      if (k == stop_at)  stop_v[sel]  = 1'b1;
    end
    last_period[sel] = e.period;
  endtask

  initial begin
    int stp, ext;
    // Reset state
    #23;
    for (int s = 0; s < 3; s++) check("reset", 0, get_obs(s), mk(0, 0, 0, 0, 0));
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table on instance 0: playback, stop, start-while-busy, start+stop
    tbl.push_back(mkv(1, 0,   1, mk(0, 0,      0, 1, 0)));
    tbl.push_back(mkv(0, 0,   1, mk(1, 190839, 0, 1, 0)));
    tbl.push_back(mkv(0, 0,  89, mk(1, 190839, 0, 1, 0)));
    tbl.push_back(mkv(0, 0,   1, mk(0, 190839, 0, 1, 0)));
    tbl.push_back(mkv(0, 0,  10, mk(0, 190839, 1, 1, 0)));
    tbl.push_back(mkv(0, 0,   1, mk(1, 170067, 1, 1, 0)));
    tbl.push_back(mkv(0, 0, 505, mk(1, 101213, 6, 1, 0)));
    tbl.push_back(mkv(0, 0,  89, mk(1, 101213, 6, 1, 0)));
    tbl.push_back(mkv(0, 0,  11, mk(0, 101213, 7, 1, 0)));
    tbl.push_back(mkv(0, 0,   1, mk(0, 101213, 7, 1, 1)));
    tbl.push_back(mkv(0, 0,   1, mk(0, 101213, 7, 0, 0)));
    tbl.push_back(mkv(1, 0,   1, mk(0, 101213, 0, 1, 0)));
    tbl.push_back(mkv(0, 0, 149, mk(1, 170067, 1, 1, 0)));
    tbl.push_back(mkv(0, 1,   1, mk(0, 170067, -1, 0, 0)));
    tbl.push_back(mkv(0, 0,  20, mk(0, 170067, -1, 0, 0)));
    tbl.push_back(mkv(1, 0,   1, mk(0, 170067, 0, 1, 0)));
    tbl.push_back(mkv(0, 0,  49, mk(1, 190839, 0, 1, 0)));
    tbl.push_back(mkv(1, 0,  52, mk(0, 190839, 1, 1, 0)));
    tbl.push_back(mkv(0, 0,   1, mk(1, 170067, 1, 1, 0)));
    tbl.push_back(mkv(0, 1,   1, mk(0, 170067, -1, 0, 0)));
    tbl.push_back(mkv(1, 1,   1, mk(0, 170067, -1, 0, 0)));
    tbl.push_back(mkv(0, 0,   5, mk(0, 170067, -1, 0, 0)));
    for (int r = 0; r < tbl.size(); r++) begin
      start_v[0] = tbl[r].st;
      stop_v[0]  = tbl[r].sp;
      for (int c = 0; c < tbl[r].n; c++) begin
        @(posedge clk); #1;
        start_v = '0; stop_v = '0;
        @(negedge clk);
      end
      check($sformatf("table%0d", r), r, get_obs(0), tbl[r].e);
    end
    last_period[0] = 170067;

    // Loop wraps to entry 0 without done; rest/long entry
    run_trace(1, 850, 0, 0, "loop");
    run_trace(2, 0, 310, 0, "rest");

    // Randomized stop points and ignored restarts
    for (int r = 0; r < 6; r++) begin
      stp = $urandom_range(900, 3);
      ext = $urandom_range((stp - 1 < 700) ? stp - 1 : 700, 2);
      run_trace(r % 2, stp, 0, ext, $sformatf("rand%0d", r));
    end

    // Reset mid-note, then replay from entry 0
    run_trace(0, 0, 40, 0, "prerst");
    rst_n = 1'b0;
    #1;
    check("rst_mid", 40, get_obs(0), mk(0, 0, 0, 0, 0));
    last_period = '{0, 0, 0};
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_trace(0, 0, 720, 0, "replay");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
